// File: rtl/universal_shift_engine_if.sv
// Command/status bundle for universal_shift_engine.
//   Start  : command strobe, sampled only while Busy=0
//   Mode   : operation select, captured with Start
//   Amount : number of single-bit steps, captured with Start
//   SerIn  : live fill bit for the serial-fill shifts
//   L      : parallel load data, captured with Start
//   Q      : register contents
//   SerOut : last bit shifted or rotated out of Q
//   Busy   : high while a command is executing
//   Done   : one-cycle completion pulse
// master drives the command side; slave is the shift engine.
interface universal_shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
);
    logic             Start;
    logic [2:0]       Mode;
    logic [CNT_W-1:0] Amount;
    logic             SerIn;
    logic [WIDTH-1:0] L;
    logic [WIDTH-1:0] Q;
    logic             SerOut;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Mode, Amount, SerIn, L,
        input  Q, SerOut, Busy, Done
    );

    modport slave (
        input  Start, Mode, Amount, SerIn, L,
        output Q, SerOut, Busy, Done
    );
endinterface

// File: rtl/universal_shift_engine.sv
// Multi-step universal shift register with start/done handshake.
// A command shifts, rotates or loads Q by a programmable number of
// single-bit steps, one step per Clock.
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset; aborts any command, no Done
//   bus   : command/status interface (slave side), see the interface file
module universal_shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic Clock,
    input  logic Reset,
    universal_shift_engine_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_ROL  = 3'b001,
        M_ROR  = 3'b010,
        M_SHLS = 3'b011,
        M_SHRS = 3'b100,
        M_SHLR = 3'b101,
        M_ASR  = 3'b110,
        M_LOAD = 3'b111
    } mode_t;

    state_t           state, state_n;
    mode_t            mode_r, mode_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] l_r, l_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic             so_r, so_n;
    logic             done_r, done_n;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            mode_r <= M_HOLD;
            cnt    <= '0;
            l_r    <= '0;
            q_r    <= '0;
            so_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            mode_r <= mode_n;
            cnt    <= cnt_n;
            l_r    <= l_n;
            q_r    <= q_n;
            so_r   <= so_n;
            done_r <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        cnt_n   = cnt;
        l_n     = l_r;
        q_n     = q_r;
        so_n    = so_r;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Start) begin
                    mode_n  = mode_t'(bus.Mode);
                    l_n     = bus.L;
                    state_n = RUN;
                    // Load always completes in one step; Amount=0 runs as a
                    // single hold step so Q and SerOut stay untouched.
                    if (mode_t'(bus.Mode) == M_LOAD) begin
                        cnt_n = CNT_W'(1);
                    end else if (bus.Amount == '0) begin
                        cnt_n  = CNT_W'(1);
                        mode_n = M_HOLD;
                    end else begin
                        cnt_n = bus.Amount;
                    end
                end
            end

            RUN: begin
                case (mode_r)
                    M_HOLD: ;
                    M_ROL: begin
                        q_n  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                        so_n = q_r[WIDTH-1];
                    end
                    M_ROR: begin
                        q_n  = {q_r[0], q_r[WIDTH-1:1]};
                        so_n = q_r[0];
                    end
                    M_SHLS: begin
                        q_n  = {q_r[WIDTH-2:0], bus.SerIn};
                        so_n = q_r[WIDTH-1];
                    end
                    M_SHRS: begin
                        q_n  = {bus.SerIn, q_r[WIDTH-1:1]};
                        so_n = q_r[0];
                    end
                    M_SHLR: begin
                        q_n  = {q_r[WIDTH-2:0], q_r[0]};
                        so_n = q_r[WIDTH-1];
                    end
                    M_ASR: begin
                        q_n  = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                        so_n = q_r[0];
                    end
                    M_LOAD: q_n = l_r;
                    default: ;
                endcase
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.Q      = q_r;
    assign bus.SerOut = so_r;
    assign bus.Busy   = (state == RUN);
    assign bus.Done   = done_r;

endmodule

// File: tb/tb_universal_shift_engine.sv
module tb_universal_shift_engine;

    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    universal_shift_engine_if #(.WIDTH(8), .CNT_W(5)) bus ();

    universal_shift_engine #(.WIDTH(8), .CNT_W(5)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // advance one rising edge, then settle away from the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // load a value and step past its Done cycle
    task automatic load_q(input logic [7:0] v);
        bus.Start = 1'b1; bus.Mode = 3'b111; bus.L = v; bus.Amount = 5'd1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.Start = 1'b1; bus.Mode = 3'b111; bus.L = 8'hFF;
        bus.Amount = 5'd3; bus.SerIn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.Q !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.SerOut !== 1'b0) begin
                failures++;
                $display("FAIL reset: Q=%h Busy=%b Done=%b SerOut=%b, required Q=00 Busy=0 Done=0 SerOut=0",
                         bus.Q, bus.Busy, bus.Done, bus.SerOut);
            end
        end
        Reset = 1'b0; bus.Start = 1'b0;
        tick();
    endtask

    task automatic test_load();
        bus.Start = 1'b1; bus.Mode = 3'b111; bus.L = 8'hA5; bus.Amount = 5'd7;
        tick();
        bus.Start = 1'b0; bus.L = 8'h00;
        checks++;
        if (bus.Busy !== 1'b1 || bus.Q !== 8'h00 || bus.Done !== 1'b0) begin
            failures++;
            $display("FAIL load_accept: Busy=%b Q=%h Done=%b, required Busy=1 Q=00 Done=0", bus.Busy, bus.Q, bus.Done);
        end
        tick();
        checks++;
        if (bus.Q !== 8'hA5 || bus.Busy !== 1'b0 || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL load_done: Q=%h Busy=%b Done=%b, required Q=a5 Busy=0 Done=1", bus.Q, bus.Busy, bus.Done);
        end
        tick();
        checks++;
        if (bus.Done !== 1'b0 || bus.Q !== 8'hA5) begin
            failures++;
            $display("FAIL load_done_pulse: Done=%b Q=%h, required Done=0 Q=a5", bus.Done, bus.Q);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h4B; exp_q[1] = 8'h96; exp_q[2] = 8'h2D;
        bus.Start = 1'b1; bus.Mode = 3'b001; bus.Amount = 5'd3;
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Q !== exp_q[i]) begin
                failures++;
                $display("FAIL rol3_step%0d: Q=%h, required %h", i + 1, bus.Q, exp_q[i]);
            end
        end
        checks++;
        if (bus.SerOut !== 1'b1 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL rol3_end: SerOut=%b Done=%b Busy=%b, required SerOut=1 Done=1 Busy=0",
                     bus.SerOut, bus.Done, bus.Busy);
        end
        // Start in the Done cycle is accepted: rotate right 10 == right 2
        bus.Start = 1'b1; bus.Mode = 3'b010; bus.Amount = 5'd10;
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
                failures++;
                $display("FAIL ror10_busy%0d: Busy=%b Done=%b, required Busy=1 Done=0", i, bus.Busy, bus.Done);
            end
            tick();
        end
        checks++;
        if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL ror10_busy9: Busy=%b, required 1", bus.Busy);
        end
        tick();
        checks++;
        if (bus.Q !== 8'h4B || bus.SerOut !== 1'b0 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL ror10_end: Q=%h SerOut=%b Done=%b Busy=%b, required Q=4b SerOut=0 Done=1 Busy=0",
                     bus.Q, bus.SerOut, bus.Done, bus.Busy);
        end
        tick();
    endtask

    task automatic test_arith();
        load_q(8'h96);
        bus.Start = 1'b1; bus.Mode = 3'b110; bus.Amount = 5'd2;
        tick();
        bus.Start = 1'b0;
        tick();
        checks++;
        if (bus.Q !== 8'hCB || bus.SerOut !== 1'b0) begin
            failures++;
            $display("FAIL asr_step1: Q=%h SerOut=%b, required Q=cb SerOut=0", bus.Q, bus.SerOut);
        end
        tick();
        checks++;
        if (bus.Q !== 8'hE5 || bus.SerOut !== 1'b1 || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL asr_step2: Q=%h SerOut=%b Done=%b, required Q=e5 SerOut=1 Done=1",
                     bus.Q, bus.SerOut, bus.Done);
        end
        bus.Start = 1'b1; bus.Mode = 3'b101; bus.Amount = 5'd1;
        tick();
        bus.Start = 1'b0;
        tick();
        checks++;
        if (bus.Q !== 8'hCB || bus.SerOut !== 1'b1 || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL shl_rep: Q=%h SerOut=%b Done=%b, required Q=cb SerOut=1 Done=1",
                     bus.Q, bus.SerOut, bus.Done);
        end
        tick();
    endtask

    task automatic test_flush();
        int busy_cycles;
        load_q(8'h00);
        busy_cycles = 0;
        bus.Start = 1'b1; bus.Mode = 3'b100; bus.Amount = 5'd9; bus.SerIn = 1'b1;
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.Busy === 1'b1) busy_cycles++;
            tick();
        end
        checks++;
        if (bus.Q !== 8'hFF || bus.SerOut !== 1'b0) begin
            failures++;
            $display("FAIL flush_e8: Q=%h SerOut=%b, required Q=ff SerOut=0", bus.Q, bus.SerOut);
        end
        if (bus.Busy === 1'b1) busy_cycles++;
        tick();
        checks++;
        if (bus.Q !== 8'hFF || bus.SerOut !== 1'b1 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_e9: Q=%h SerOut=%b Done=%b Busy=%b, required Q=ff SerOut=1 Done=1 Busy=0",
                     bus.Q, bus.SerOut, bus.Done, bus.Busy);
        end
        checks++;
        if (busy_cycles != 9) begin
            failures++;
            $display("FAIL flush_busy_len: %0d cycles, required 9", busy_cycles);
        end
        tick();
    endtask

    task automatic test_live_serin();
        logic [2:0] bits;
        bits = 3'b101;
        load_q(8'h00);
        bus.Start = 1'b1; bus.Mode = 3'b011; bus.Amount = 5'd3;
        tick();
        bus.Start = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            bus.SerIn = bits[i];
            tick();
        end
        checks++;
        if (bus.Q !== 8'h05 || bus.SerOut !== 1'b0 || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL live_serin: Q=%h SerOut=%b Done=%b, required Q=05 SerOut=0 Done=1",
                     bus.Q, bus.SerOut, bus.Done);
        end
        tick();
    endtask

    task automatic test_amount_zero();
        bus.Start = 1'b1; bus.Mode = 3'b010; bus.Amount = 5'd0;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL amt0_busy: Busy=%b, required 1", bus.Busy);
        end
        tick();
        checks++;
        if (bus.Q !== 8'h05 || bus.SerOut !== 1'b0 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL amt0_end: Q=%h SerOut=%b Done=%b Busy=%b, required Q=05 SerOut=0 Done=1 Busy=0",
                     bus.Q, bus.SerOut, bus.Done, bus.Busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // Start during RUN is ignored
        load_q(8'h3C);
        bus.Start = 1'b1; bus.Mode = 3'b001; bus.Amount = 5'd5;
        tick();
        bus.Start = 1'b0;
        tick();
        bus.Start = 1'b1; bus.Mode = 3'b111; bus.L = 8'h00; bus.Amount = 5'd1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL ignore_mid: Done=%b Busy=%b, required Done=0 Busy=1", bus.Done, bus.Busy);
        end
        tick();
        checks++;
        if (bus.Q !== 8'h87 || bus.SerOut !== 1'b1 || bus.Done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_end: Q=%h SerOut=%b Done=%b, required Q=87 SerOut=1 Done=1",
                     bus.Q, bus.SerOut, bus.Done);
        end
        tick();
        checks++;
        if (bus.Busy !== 1'b0 || bus.Q !== 8'h87) begin
            failures++;
            $display("FAIL ignore_no_requeue: Busy=%b Q=%h, required Busy=0 Q=87", bus.Busy, bus.Q);
        end
        // Reset aborts mid-command with no Done
        load_q(8'h3C);
        bus.Start = 1'b1; bus.Mode = 3'b001; bus.Amount = 5'd5;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        checks++;
        if (bus.Q !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.SerOut !== 1'b0) begin
            failures++;
            $display("FAIL abort: Q=%h Busy=%b Done=%b SerOut=%b, required Q=00 Busy=0 Done=0 SerOut=0",
                     bus.Q, bus.Busy, bus.Done, bus.SerOut);
        end
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Q !== 8'h00) begin
                failures++;
                $display("FAIL abort_after%0d: Done=%b Busy=%b Q=%h, required Done=0 Busy=0 Q=00",
                         i, bus.Done, bus.Busy, bus.Q);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b0;
        bus.Start = 1'b0; bus.Mode = 3'b000; bus.Amount = '0; bus.SerIn = 1'b0; bus.L = '0;
        test_reset();
        test_load();
        test_rotate();
        test_arith();
        test_flush();
        test_live_serin();
        test_amount_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
